// File: rtl/reg_bus_arb_if.sv
// reg_bus_arb_if: register request/ack bus between a requester (master modport) and a responder (slave modport)
interface reg_bus_arb_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  rd_wr_L;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rd_data;
  modport master (output req, rd_wr_L, addr, wr_data, input ack, rd_data);
  modport slave (input req, rd_wr_L, addr, wr_data, output ack, rd_data);
endinterface

// File: rtl/reg_bus_arb.sv
// reg_bus_arb: round-robin two-master arbiter onto one register target port, one transaction in flight.
// REG_ARB_TIMEOUT_EN adds a WAIT_ACK timeout that completes with 0xDEADBEEF and pulses timeout_err.
module reg_bus_arb #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CNT = 511
) (
  input  logic          clk,
  input  logic          reset_n,
  reg_bus_arb_if.slave  m0,
  reg_bus_arb_if.slave  m1,
  reg_bus_arb_if.master tgt,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;
  localparam logic [DATA_WIDTH-1:0] DEAD = DATA_WIDTH'(32'hDEADBEEF);
  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  req_q, req_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  terr_q, terr_d;
  logic                  sel, done, expired;
  logic [DATA_WIDTH-1:0] done_data;
`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CNT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // ack wins over a counter that reaches zero in the same cycle
  assign expired = state_q == WAIT_ACK && !tgt.ack && cnt_q == '0;
  assign cnt_d = state_q != WAIT_ACK ? CW'(TIMEOUT_CNT) : cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expired = 1'b0;
`endif
  assign sel = m0.req && m1.req ? !last_q : m1.req;
  assign done = state_q == WAIT_ACK && (tgt.ack || expired);
  assign done_data = !rw_q ? '0 : tgt.ack ? tgt.rd_data : DEAD;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    req_d = req_q;
    rw_d = rw_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    terr_d = 1'b0;
    case (state_q)
      IDLE: if (m0.req || m1.req) begin
        state_d = WAIT_ACK;
        last_d = sel;
        req_d = 1'b1;
        rw_d = sel ? m1.rd_wr_L : m0.rd_wr_L;
        addr_d = sel ? m1.addr : m0.addr;
        wdata_d = sel ? m1.wr_data : m0.wr_data;
      end
      WAIT_ACK: if (done) begin
        state_d = RELEASE;
        req_d = 1'b0;
        rw_d = 1'b1;
        ack0_d = !last_q;
        ack1_d = last_q;
        rdata0_d = last_q ? rdata0_q : done_data;
        rdata1_d = last_q ? done_data : rdata1_q;
        terr_d = expired;
      end
      // a level-held ack must drop before the next access can start
      default: state_d = tgt.ack ? RELEASE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      req_q <= 1'b0;
      rw_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      req_q <= req_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      terr_q <= terr_d;
    end
  assign tgt.req = req_q;
  assign tgt.rd_wr_L = rw_q;
  assign tgt.addr = addr_q;
  assign tgt.wr_data = wdata_q;
  assign m0.ack = ack0_q;
  assign m0.rd_data = rdata0_q;
  assign m1.ack = ack1_q;
  assign m1.rd_data = rdata1_q;
  assign timeout_err = terr_q;
endmodule

// File: doc/reg_bus_arb.md
Name: reg_bus_arb

Overview:
- Two-master arbiter for the register request/ack bus that feeds the register decoder and its targets (SRAM and user-datapath register blocks).
- Shares one downstream req/ack target port between master 0 (host CPU path) and master 1 (local management/statistics engine).
- Round-robin grant; one outstanding transaction at a time.
- Per-access timeout returns 0xDEADBEEF so a dead target cannot stall either master.

Parameters:
ADDR_WIDTH, 23, word address width of masters and target port
DATA_WIDTH, 32, register data width
TIMEOUT_CNT, 511, cycles in WAIT_ACK before forced completion (only with REG_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request, level, held until m0_ack
m0_rd_wr_L  in  1  1=read 0=write
m0_addr  in  ADDR_WIDTH  word address
m0_wr_data  in  DATA_WIDTH  write data
m0_ack  out  1  one-cycle completion pulse
m0_rd_data  out  DATA_WIDTH  read data, valid with m0_ack
m1_req, m1_rd_wr_L, m1_addr, m1_wr_data, m1_ack, m1_rd_data  same as m0_* for master 1
reg_req  out  1  target request, held until completion
reg_rd_wr_L  out  1  target direction
reg_addr  out  ADDR_WIDTH  target address
reg_wr_data  out  DATA_WIDTH  target write data
reg_ack  in  1  target ack (level or pulse)
reg_rd_data  in  DATA_WIDTH  target read data, sampled with reg_ack
timeout_err  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0, except reg_rd_wr_L=1.
  - state=IDLE; last_grant=1, so master 0 wins the first tie.
  - Reset mid-transaction drops reg_req immediately; the in-flight access is abandoned with no master ack.
- All outputs are registered.
- IDLE:
  - If only one mN_req=1, grant it. If both, grant the master != last_grant.
  - Latch that master's rd_wr_L/addr/wr_data onto reg_*; set reg_req=1, last_grant=N; go to WAIT_ACK.
  - Latency: mN_req sampled high at edge T -> reg_req=1 after edge T.
- WAIT_ACK:
  - reg_req held 1; reg_* stable.
  - On reg_ack=1: reg_req<=0; mN_ack<=1 for one cycle; mN_rd_data <= reg_rd_data if read, 0 if write; reg_rd_wr_L<=1; go to RELEASE.
  - mN_ack appears one cycle after reg_ack is sampled.
  - Timeout (feature on): counter loads TIMEOUT_CNT on entry and decrements each WAIT_ACK cycle. If it reaches 0 with no reg_ack, complete as above with rd_data=32'hDEADBEEF (writes: 0) and pulse timeout_err.
  - reg_ack in the same cycle the counter hits 0: treat as a normal ack; no timeout_err.
- RELEASE:
  - The served master's req is ignored this cycle; masters must drop req the cycle after ack.
  - Stay in RELEASE while reg_ack=1, so a level-held ack is not counted for the next access. Go to IDLE when reg_ack=0.
  - Minimum back-to-back spacing is one RELEASE cycle plus one IDLE cycle.
- mN_rd_data holds its value until the next completion to that master.
- The non-granted master waits with req held; there is no starvation because round-robin guarantees a grant within one transaction.
- reg_ack in IDLE or RELEASE with no outstanding req: ignored.
- m_ack is never asserted to both masters in the same cycle.

Optional Feature:
REG_ARB_TIMEOUT_EN
- Defined: timeout counter, forced 0xDEADBEEF completion and timeout_err pulse, as above.
- Undefined: no counter; WAIT_ACK waits indefinitely for reg_ack; timeout_err tied 0; TIMEOUT_CNT unused.

Test Plan:
- m0 read addr 0x000010; target acks 3 cycles after reg_req with 0x12345678 -> reg_req high 3 cycles, m0_ack one pulse with m0_rd_data=0x12345678, m1_ack stays 0.
- m0 and m1 request in the same cycle after reset -> m0 served first, then m1; a second simultaneous pair -> m0 then m1 again (alternation relative to last_grant).
- m1 write 0xA5A5A5A5 to 0x400004 -> reg_rd_wr_L=0, reg_wr_data=0xA5A5A5A5 during req; m1_ack pulse; m1_rd_data=0.
- Feature on, target never acks m0 read -> after 512 WAIT_ACK cycles: m0_ack pulse, m0_rd_data=0xDEADBEEF, timeout_err pulse. Feature off -> reg_req stays high indefinitely.
- Target holds reg_ack high 5 cycles while m1 requests -> m1's reg_req is not asserted until after reg_ack falls; no spurious m1_ack.
- reset_n asserted during WAIT_ACK -> reg_req=0 immediately (asynchronous); no mN_ack; after release, a fresh m0 request completes normally.
